// File: rtl/proj_frame_sched.sv
// proj_frame_sched: frame-level scheduler for one axis of the projection
// bitmap RAM. Each frame cycle it clears the RAM, marks object columns for
// one video frame, scans the RAM for the occupied span and publishes
// margin-adjusted bounds.
// Optional feature: define PROJ_MIN_RUN_FILTER_EN to ignore runs of 1s
// shorter than MIN_RUN when choosing the bounds.
module proj_frame_sched #(
  parameter int IMG_WIDTH_LINE = 1024,
  parameter int MARGIN_LO      = 0,
  parameter int MARGIN_HI      = 0,
  parameter int MIN_RUN        = 4
) (
  input  logic        pixelclk,
  input  logic        reset,
  input  logic        en,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic        i_mark,
  input  logic [11:0] i_coord,
  output logic        ram_we,
  output logic [11:0] ram_waddr,
  output logic        ram_wdata,
  output logic [11:0] ram_raddr,
  input  logic        ram_rdata,
  output logic [11:0] o_lo,
  output logic [11:0] o_hi,
  output logic        o_found,
  output logic        o_valid,
  output logic        o_busy,
  output logic [7:0]  o_frame_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_VS, ACCUM, SCAN, PUBLISH} state_t;

  localparam logic [11:0] LAST  = 12'(IMG_WIDTH_LINE - 1);
  localparam logic [12:0] DEPTH = 13'(IMG_WIDTH_LINE);

  state_t      state, state_nx;
  logic        vs_r;
  logic        vs_fall;
  logic        we_nx, wdata_nx;
  logic [11:0] waddr_nx, raddr_nx;
  logic        rd_vld, rd_vld_nx;   // ram_rdata holds the bit of rd_addr
  logic [11:0] rd_addr, rd_addr_nx;
  logic        drain, drain_nx;     // last address issued, evaluating its bit
  logic        acc_any, any_upd, any_nx;
  logic [11:0] acc_lo, lo_upd, lo_nx;
  logic [11:0] acc_hi, hi_upd, hi_nx;
  logic [12:0] lo_sum;
  logic [11:0] lo_adj, hi_adj;
  logic        pub_found;
  logic [11:0] o_lo_nx, o_hi_nx;
  logic        o_found_nx, o_valid_nx;
  logic [7:0]  cnt_nx;
`ifdef PROJ_MIN_RUN_FILTER_EN
  logic        in_run, in_run_upd, in_run_nx;
  logic [11:0] run_start, start_upd, start_nx;
  logic [11:0] run_len, len_upd, len_nx;
  logic        run_close;
  logic [11:0] close_start, close_end, close_len;
`endif

  assign vs_fall = vs_r & ~i_vs;
  assign o_busy  = (state != IDLE);

  // Scan evaluation: fold the bit returned for rd_addr into the span accumulators.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    any_upd = acc_any;
    lo_upd  = acc_lo;
    hi_upd  = acc_hi;
`ifdef PROJ_MIN_RUN_FILTER_EN
    in_run_upd  = in_run;
    start_upd   = run_start;
    len_upd     = run_len;
    run_close   = 1'b0;
    close_start = run_start;
    close_end   = rd_addr;
    close_len   = run_len;
    if (rd_vld) begin
      if (ram_rdata) begin
        if (!in_run) begin
          in_run_upd = 1'b1;
          start_upd  = rd_addr;
          len_upd    = 12'd1;
        end else if (run_len != 12'hFFF) begin
          len_upd = run_len + 12'd1;
        end
        // A run still open at the last address closes in the drain cycle.
        if (drain) begin
          run_close   = 1'b1;
          close_start = start_upd;
          close_end   = rd_addr;
          close_len   = len_upd;
          in_run_upd  = 1'b0;
        end
      end else if (in_run) begin
        run_close   = 1'b1;
        close_start = run_start;
        close_end   = rd_addr - 12'd1;
        close_len   = run_len;
        in_run_upd  = 1'b0;
      end
    end
    if (run_close && ({1'b0, close_len} >= 13'(MIN_RUN))) begin
      if (!acc_any) lo_upd = close_start;
      hi_upd  = close_end;
      any_upd = 1'b1;
    end
`else
    if (rd_vld && ram_rdata) begin
      if (!acc_any) lo_upd = rd_addr;
      hi_upd  = rd_addr;
      any_upd = 1'b1;
    end
`endif
  end

  // Margin adjustment of the final span, consumed on the edge entering PUBLISH.
  always_comb begin
    lo_sum    = {1'b0, lo_upd} + 13'(MARGIN_LO);
    lo_adj    = (lo_sum > {1'b0, LAST}) ? LAST : lo_sum[11:0];
    hi_adj    = ({1'b0, hi_upd} >= 13'(MARGIN_HI)) ? (hi_upd - 12'(MARGIN_HI)) : 12'd0;
    pub_found = any_upd && (lo_adj <= hi_adj);
  end

  // Next-state and next-register values for the phase sequencer.
  always_comb begin
    state_nx   = state;
    we_nx      = 1'b0;
    waddr_nx   = ram_waddr;
    wdata_nx   = 1'b0;
    raddr_nx   = 12'd0;
    rd_vld_nx  = 1'b0;
    rd_addr_nx = rd_addr;
    drain_nx   = 1'b0;
    any_nx     = acc_any;
    lo_nx      = acc_lo;
    hi_nx      = acc_hi;
    o_lo_nx    = o_lo;
    o_hi_nx    = o_hi;
    o_found_nx = o_found;
    o_valid_nx = 1'b0;
    cnt_nx     = o_frame_cnt;
`ifdef PROJ_MIN_RUN_FILTER_EN
    in_run_nx = in_run;
    start_nx  = run_start;
    len_nx    = run_len;
`endif
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = CLEAR;
          we_nx    = 1'b1;
          waddr_nx = 12'd0;
        end
      end
      CLEAR: begin
        if (ram_waddr == LAST) begin
          state_nx = WAIT_VS;
        end else begin
          we_nx    = 1'b1;
          waddr_nx = ram_waddr + 12'd1;
        end
      end
      WAIT_VS: begin
        if (vs_fall) state_nx = ACCUM;
      end
      ACCUM: begin
        if (i_de && i_mark && ({1'b0, i_coord} < DEPTH)) begin
          we_nx    = 1'b1;
          waddr_nx = i_coord;
          wdata_nx = 1'b1;
        end
        if (vs_fall) begin
          state_nx = SCAN;
          any_nx   = 1'b0;
          lo_nx    = 12'd0;
          hi_nx    = 12'd0;
`ifdef PROJ_MIN_RUN_FILTER_EN
          in_run_nx = 1'b0;
          start_nx  = 12'd0;
          len_nx    = 12'd0;
`endif
        end
      end
      SCAN: begin
        any_nx = any_upd;
        lo_nx  = lo_upd;
        hi_nx  = hi_upd;
`ifdef PROJ_MIN_RUN_FILTER_EN
        in_run_nx = in_run_upd;
        start_nx  = start_upd;
        len_nx    = len_upd;
`endif
        if (drain) begin
          state_nx   = PUBLISH;
          o_valid_nx = 1'b1;
          o_found_nx = pub_found;
          cnt_nx     = o_frame_cnt + 8'd1;
          if (pub_found) begin
            o_lo_nx = lo_adj;
            o_hi_nx = hi_adj;
          end
        end else begin
          rd_vld_nx  = 1'b1;
          rd_addr_nx = ram_raddr;
          if (ram_raddr == LAST) drain_nx = 1'b1;
          else                   raddr_nx = ram_raddr + 12'd1;
        end
      end
      PUBLISH: begin
        state_nx = CLEAR;
        we_nx    = 1'b1;
        waddr_nx = 12'd0;
      end
      default: state_nx = IDLE;
    endcase
    // Disabling wins over every phase; published results are left untouched.
    if (!en) begin
      state_nx   = IDLE;
      we_nx      = 1'b0;
      waddr_nx   = 12'd0;
      wdata_nx   = 1'b0;
      raddr_nx   = 12'd0;
      rd_vld_nx  = 1'b0;
      drain_nx   = 1'b0;
      o_lo_nx    = o_lo;
      o_hi_nx    = o_hi;
      o_found_nx = o_found;
      o_valid_nx = 1'b0;
      cnt_nx     = o_frame_cnt;
    end
  end

  // State, RAM strobes, scan accumulators and published outputs.
  always_ff @(posedge pixelclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      vs_r        <= 1'b0;
      ram_we      <= 1'b0;
      ram_waddr   <= 12'd0;
      ram_wdata   <= 1'b0;
      ram_raddr   <= 12'd0;
      rd_vld      <= 1'b0;
      rd_addr     <= 12'd0;
      drain       <= 1'b0;
      acc_any     <= 1'b0;
      acc_lo      <= 12'd0;
      acc_hi      <= 12'd0;
      o_lo        <= 12'd0;
      o_hi        <= 12'd0;
      o_found     <= 1'b0;
      o_valid     <= 1'b0;
      o_frame_cnt <= 8'd0;
`ifdef PROJ_MIN_RUN_FILTER_EN
      in_run      <= 1'b0;
      run_start   <= 12'd0;
      run_len     <= 12'd0;
`endif
    end else begin
      state       <= state_nx;
      vs_r        <= i_vs;
      ram_we      <= we_nx;
      ram_waddr   <= waddr_nx;
      ram_wdata   <= wdata_nx;
      ram_raddr   <= raddr_nx;
      rd_vld      <= rd_vld_nx;
      rd_addr     <= rd_addr_nx;
      drain       <= drain_nx;
      acc_any     <= any_nx;
      acc_lo      <= lo_nx;
      acc_hi      <= hi_nx;
      o_lo        <= o_lo_nx;
      o_hi        <= o_hi_nx;
      o_found     <= o_found_nx;
      o_valid     <= o_valid_nx;
      o_frame_cnt <= cnt_nx;
`ifdef PROJ_MIN_RUN_FILTER_EN
      in_run      <= in_run_nx;
      run_start   <= start_nx;
      run_len     <= len_nx;
`endif
    end
  end

endmodule

// File: doc/proj_frame_sched.md
# proj_frame_sched

Frame-level scheduler for the single-axis projection bitmap RAM used by the fruit bounding-box path. Over repeating frame cycles it runs four phases: clear the RAM, mark columns during one video frame, scan the RAM for the occupied span, and publish the margin-adjusted bounds. One instance drives one axis; the horizontal and vertical projections each get their own instance and RAM.

## Interface
- IMG_WIDTH_LINE, 1024: RAM depth and number of coordinates scanned (2..4096).
- MARGIN_LO, 0: value added to the detected low bound.
- MARGIN_HI, 0: value subtracted from the detected high bound.
- MIN_RUN, 4: minimum run length in addresses; used only when PROJ_MIN_RUN_FILTER_EN is defined.

Ports:
- pixelclk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- i_vs  in  1  frame sync; its falling edge marks a frame boundary.
- i_de  in  1  active-pixel qualifier.
- i_mark  in  1  current pixel belongs to the object.
- i_coord  in  12  pixel coordinate on this axis (hcount or vcount).
- ram_we  out  1  RAM write enable.
- ram_waddr  out  12  RAM write address.
- ram_wdata  out  1  RAM write data.
- ram_raddr  out  12  RAM read address.
- ram_rdata  in  1  RAM read data; valid 1 cycle after ram_raddr.
- o_lo, o_hi  out  12  published bounds.
- o_found  out  1  the published bounds are meaningful.
- o_valid  out  1  one-cycle strobe when o_lo, o_hi and o_found update.
- o_busy  out  1  high in every state except IDLE.
- o_frame_cnt  out  8  count of publishes; wraps from 255 to 0.

## Operation
- vs_fall = vs_r & !i_vs, where vs_r is i_vs registered.
- States: IDLE, CLEAR, WAIT_VS, ACCUM, SCAN, PUBLISH.
- IDLE:
  - All RAM strobes are 0.
  - If en=1, go to CLEAR.
- CLEAR:
  - Drive ram_we=1, ram_wdata=0, ram_waddr=0..IMG_WIDTH_LINE-1, one address per cycle.
  - After the last address, go to WAIT_VS.
- WAIT_VS: on vs_fall, go to ACCUM.
- ACCUM:
  - Each cycle, if i_de & i_mark & (i_coord < IMG_WIDTH_LINE): ram_we=1, ram_waddr=i_coord, ram_wdata=1. Otherwise ram_we=0.
  - Coordinates at or above IMG_WIDTH_LINE are dropped silently.
  - On the next vs_fall, go to SCAN.
- SCAN:
  - ram_raddr steps 0..IMG_WIDTH_LINE-1. The returned bit is evaluated 1 cycle later against the delayed address.
  - A run is a maximal sequence of consecutive 1s. The run ending at address IMG_WIDTH_LINE-1 closes in the drain cycle.
  - lo_raw = start of the first qualifying run.
  - hi_raw = end of the last qualifying run.
  - After the drain cycle, go to PUBLISH.
- PUBLISH:
  - lo_adj = min(lo_raw + MARGIN_LO, IMG_WIDTH_LINE-1), computed 13-bit then saturated.
  - hi_adj = hi_raw >= MARGIN_HI ? hi_raw - MARGIN_HI : 0.
  - o_found = 1 only if at least one run qualified and lo_adj <= hi_adj.
  - If o_found=1: load o_lo=lo_adj, o_hi=hi_adj.
  - If o_found=0: o_lo and o_hi hold their previous values.
  - Assert o_valid, increment o_frame_cnt, go to CLEAR.
- Boundary rules:
  - vs_fall in CLEAR, SCAN or PUBLISH is ignored. That frame is skipped and WAIT_VS synchronises on a later frame.
  - en=0 in any state: go to IDLE on the next edge with RAM strobes 0. Scan accumulators are discarded; o_lo, o_hi, o_found and o_frame_cnt hold. Re-enabling always starts with CLEAR.
  - An all-zero RAM gives o_found=0.
  - A single 1 at address IMG_WIDTH_LINE-1 gives lo_raw = hi_raw = IMG_WIDTH_LINE-1 (subject to the filter).

## Timing
- Reset (synchronous; takes effect on the pixelclk edge where reset=1):
  - State is IDLE.
  - ram_we, ram_waddr, ram_wdata and ram_raddr are 0.
  - o_lo, o_hi, o_found, o_valid, o_busy and o_frame_cnt are 0.
  - vs_r is 0.
- CLEAR lasts exactly IMG_WIDTH_LINE cycles.
- SCAN lasts IMG_WIDTH_LINE+1 cycles.
- PUBLISH lasts 1 cycle. o_valid is high for that cycle, and the output registers update on the same edge that raises it.
- In ACCUM, write strobes are registered: the write occurs 1 cycle after the qualifying pixel.
- The first pixel after vs_fall is captured only if ACCUM was entered on that vs_fall edge. ACCUM is entered on the edge that samples vs_fall.
- Minimum cycle: CLEAR + WAIT_VS + one frame + SCAN + 1 cycle.

## Configuration
- PROJ_MIN_RUN_FILTER_EN defined:
  - A run qualifies only if its length >= MIN_RUN.
  - Run length is counted with a 12-bit saturating counter.
- PROJ_MIN_RUN_FILTER_EN undefined:
  - Every run qualifies.
  - lo_raw = first 1, hi_raw = last 1.
  - No run-length counter is built.

## Test plan
- IMG_WIDTH_LINE=16, margins 0, no filter. Reset, then en=1 → ram_we=1 for 16 cycles with waddr 0..15 and wdata=0, then WAIT_VS; all outputs 0 until the first PUBLISH.
- Marks at coords 3..9 in one frame → after SCAN: o_valid pulse, o_lo=3, o_hi=9, o_found=1, o_frame_cnt=1.
- MARGIN_LO=2, MARGIN_HI=2, marks at 5..6 → lo_adj=7 > hi_adj=4, so o_found=0 and o_lo/o_hi keep their previous values.
- Filter defined, MIN_RUN=4, marks at {1,2} and {6..10} and {14} → o_lo=6, o_hi=10.
- Marks at i_coord=15 and i_coord=20 → only address 15 written; o_lo=o_hi=15.
- en dropped mid-SCAN → IDLE next edge, no o_valid, outputs unchanged. en raised again → full CLEAR of 16 cycles.
